// File: rtl/psx_serial_uart_rx_if.sv
// rtl/psx_serial_uart_rx_if.sv - serial line in / byte strobe out bundle for the PSX UART receiver
//   rx_pin    : raw serial line (idle high), driven by the board side
//   rx_data   : last received byte
//   rx_strobe : one-cycle pulse, new byte in rx_data
//   rx_idle   : inter-packet idle level
//   frame_err : one-cycle pulse, stop bit sampled low
//   brk       : line-break level
//   master = receiver, slave = line driver / byte consumer
interface psx_serial_uart_rx_if;
    logic       rx_pin;
    logic [7:0] rx_data;
    logic       rx_strobe;
    logic       rx_idle;
    logic       frame_err;
    logic       brk;

    modport master (
        input  rx_pin,
        output rx_data, rx_strobe, rx_idle, frame_err, brk
    );

    modport slave (
        output rx_pin,
        input  rx_data, rx_strobe, rx_idle, frame_err, brk
    );
endinterface

// File: rtl/psx_serial_uart_rx.sv
// rtl/psx_serial_uart_rx.sv - oversampling 8N1 receiver with idle, framing-error and break reporting
//   FIFO_clk : receiver clock
//   reset    : asynchronous, active-high
//   bus      : psx_serial_uart_rx_if.master (rx_pin in; rx_data, rx_strobe, rx_idle, frame_err, brk out)
//   CLK_DIV    : clock cycles per bit (8..65535)
//   IDLE_BITS  : mark bit-times before rx_idle rises (2..255)
//   BREAK_BITS : space bit-times before brk rises (11..255)
module psx_serial_uart_rx #(
    parameter int CLK_DIV    = 1250,
    parameter int IDLE_BITS  = 20,
    parameter int BREAK_BITS = 12
) (
    input  logic                         FIFO_clk,
    input  logic                         reset,
    psx_serial_uart_rx_if.master         bus
);
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] CENTRE   = 16'(CLK_DIV / 2);
    localparam logic [7:0]  IDLE_LIM = 8'(IDLE_BITS);
    localparam logic [7:0]  BRK_LIM  = 8'(BREAK_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_MARK
    } state_t;

    state_t      state, state_nxt;
    logic        sync1, s;
    logic [15:0] bit_cnt;
    logic [2:0]  data_cnt;
    logic [7:0]  shreg;
    logic        vote_a, vote_b;
    logic [15:0] idle_tick, brk_tick;
    logic [7:0]  idle_cnt, brk_cnt;
    logic [7:0]  rx_data_q;
    logic        strobe_q, ferr_q, idle_q, brk_q;

    logic        vote, at_vote, at_end;
    logic        strobe_nxt, ferr_nxt, load_data, shift_en;

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_strobe = strobe_q;
    assign bus.rx_idle   = idle_q;
    assign bus.frame_err = ferr_q;
    assign bus.brk       = brk_q;

    // Samples at centre-1 and centre are held; the third comes live at centre+1.
    assign vote    = (vote_a & vote_b) | (vote_a & s) | (vote_b & s);
    assign at_vote = (bit_cnt == CENTRE + 16'd1);
    assign at_end  = (bit_cnt == DIV_LAST);

    always_ff @(posedge FIFO_clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            s     <= 1'b1;
        end else begin
            sync1 <= bus.rx_pin;
            s     <= sync1;
        end
    end

    always_comb begin
        state_nxt  = state;
        strobe_nxt = 1'b0;
        ferr_nxt   = 1'b0;
        load_data  = 1'b0;
        shift_en   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!s) state_nxt = S_START;
            end
            S_START: begin
                // Vote point always precedes bit end, so reaching bit end means the start bit held.
                if (at_vote && vote) state_nxt = S_IDLE;
                else if (at_end)     state_nxt = S_DATA;
            end
            S_DATA: begin
                shift_en = at_vote;
                if (at_end && data_cnt == 3'd7) state_nxt = S_STOP;
            end
            S_STOP: begin
                // Leave at the stop-bit centre so a back-to-back start edge is not missed.
                if (at_vote) begin
                    if (vote) begin
                        state_nxt  = S_IDLE;
                        load_data  = !brk_q;
                        strobe_nxt = !brk_q;
                    end else begin
                        state_nxt = S_WAIT_MARK;
                        ferr_nxt  = !brk_q;
                    end
                end
            end
            S_WAIT_MARK: begin
                if (s) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge FIFO_clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            bit_cnt   <= 16'd0;
            data_cnt  <= 3'd0;
            shreg     <= 8'd0;
            vote_a    <= 1'b0;
            vote_b    <= 1'b0;
            rx_data_q <= 8'd0;
            strobe_q  <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            strobe_q <= strobe_nxt;
            ferr_q   <= ferr_nxt;

            if (state == S_IDLE || state == S_WAIT_MARK || state_nxt == S_IDLE || at_end)
                bit_cnt <= 16'd0;
            else
                bit_cnt <= bit_cnt + 16'd1;

            if (bit_cnt == CENTRE - 16'd1) vote_a <= s;
            if (bit_cnt == CENTRE)         vote_b <= s;

            if (state == S_IDLE)
                data_cnt <= 3'd0;
            else if (state == S_DATA && at_end)
                data_cnt <= data_cnt + 3'd1;

            if (shift_en)  shreg     <= {vote, shreg[7:1]};
            if (load_data) rx_data_q <= shreg;
        end
    end

    // Idle timer: whole bit-times of mark seen while waiting for a start bit.
    always_ff @(posedge FIFO_clk or posedge reset) begin
        if (reset) begin
            idle_tick <= 16'd0;
            idle_cnt  <= 8'd0;
            idle_q    <= 1'b1;
        end else begin
            if (state != S_IDLE || !s) begin
                idle_tick <= 16'd0;
                idle_cnt  <= 8'd0;
            end else if (idle_cnt != IDLE_LIM) begin
                if (idle_tick == DIV_LAST) begin
                    idle_tick <= 16'd0;
                    idle_cnt  <= idle_cnt + 8'd1;
                end else begin
                    idle_tick <= idle_tick + 16'd1;
                end
            end

            if (state == S_IDLE && !s)
                idle_q <= 1'b0;
            else if (idle_cnt == IDLE_LIM)
                idle_q <= 1'b1;
        end
    end

    // Break detector: whole bit-times of continuous space, independent of frame state.
    always_ff @(posedge FIFO_clk or posedge reset) begin
        if (reset) begin
            brk_tick <= 16'd0;
            brk_cnt  <= 8'd0;
            brk_q    <= 1'b0;
        end else if (s) begin
            brk_tick <= 16'd0;
            brk_cnt  <= 8'd0;
            brk_q    <= 1'b0;
        end else begin
            if (brk_cnt != BRK_LIM) begin
                if (brk_tick == DIV_LAST) begin
                    brk_tick <= 16'd0;
                    brk_cnt  <= brk_cnt + 8'd1;
                end else begin
                    brk_tick <= brk_tick + 16'd1;
                end
            end
            if (brk_cnt == BRK_LIM) brk_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_psx_serial_uart_rx.sv
// tb/tb_psx_serial_uart_rx.sv - self-checking bench for psx_serial_uart_rx
module tb_psx_serial_uart_rx;
    localparam int CLK_DIV    = 16;
    localparam int IDLE_BITS  = 4;
    localparam int BREAK_BITS = 12;
    localparam int LAT_NOM    = CLK_DIV * 9 + CLK_DIV / 2 + 3;

    logic FIFO_clk = 1'b0;
    logic reset    = 1'b1;

    psx_serial_uart_rx_if bus ();

    psx_serial_uart_rx #(
        .CLK_DIV    (CLK_DIV),
        .IDLE_BITS  (IDLE_BITS),
        .BREAK_BITS (BREAK_BITS)
    ) dut (
        .FIFO_clk (FIFO_clk),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 FIFO_clk = ~FIFO_clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_start  = 0;
    int strobe_cyc = 0;
    int n_strobe = 0, n_ferr = 0, n_both = 0, n_wide = 0, n_idle_coinc = 0;
    logic prev_strobe = 1'b0, prev_ferr = 1'b0, prev_idle = 1'b1;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] last_byte = 8'h00;

    always @(posedge FIFO_clk) cyc <= cyc + 1;

    // Observation of output pulses, sampled away from the active edge.
    always @(negedge FIFO_clk) begin
        if (bus.rx_strobe) begin
            rx_q.push_back(bus.rx_data);
            n_strobe++;
            strobe_cyc = cyc;
        end
        if (bus.frame_err) n_ferr++;
        if (bus.rx_strobe && bus.frame_err) n_both++;
        if ((bus.rx_strobe && prev_strobe) || (bus.frame_err && prev_ferr)) n_wide++;
        if (bus.rx_strobe && bus.rx_idle && !prev_idle) n_idle_coinc++;
        prev_strobe = bus.rx_strobe;
        prev_ferr   = bus.frame_err;
        prev_idle   = bus.rx_idle;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_bits(input int n);
        repeat (n * CLK_DIV) @(negedge FIFO_clk);
    endtask

    // Drives one 8N1 frame; rst_bit >= 0 holds reset from that bit until the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rst_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge FIFO_clk);
            bus.rx_pin = f[i];
            if (i == 0) t_start = cyc;
            if (i == rst_bit) reset = 1'b1;
            if (i == 9 && rst_bit >= 0) reset = 1'b0;
            repeat (CLK_DIV - 1) @(negedge FIFO_clk);
        end
    endtask

    task automatic send_good(input logic [7:0] b);
        exp_q.push_back(b);
        last_byte = b;
        send_frame(b, 1'b1, -1);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (!bus.rx_idle && k < 40 * CLK_DIV) begin
            @(negedge FIFO_clk);
            k++;
        end
        chk(tag, int'(bus.rx_idle), 1);
    endtask

    task automatic check_bytes(input string tag);
        chk({tag, "_count"}, rx_q.size(), exp_q.size());
        while (rx_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_byte"}, int'(rx_q.pop_front()), int'(exp_q.pop_front()));
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int s0, f0, lat;
        logic [7:0] rb;

        bus.rx_pin = 1'b1;
        reset = 1'b1;
        repeat (4) @(negedge FIFO_clk);
        chk("reset_rx_data", int'(bus.rx_data), 0);
        chk("reset_rx_strobe", int'(bus.rx_strobe), 0);
        chk("reset_rx_idle", int'(bus.rx_idle), 1);
        chk("reset_frame_err", int'(bus.frame_err), 0);
        chk("reset_brk", int'(bus.brk), 0);
        reset = 1'b0;

        // Single frame, latency and idle recovery
        wait_bits(10);
        s0 = n_strobe;
        send_good(8'hA5);
        chk("t1_idle_low_after_frame", int'(bus.rx_idle), 0);
        lat = strobe_cyc - t_start;
        n_assert++;
        assert (lat >= LAT_NOM - 3 && lat <= LAT_NOM + 3) else begin
            n_fail++;
            $error("FAIL t1_latency observed=%0d expected=%0d+-3", lat, LAT_NOM);
        end
        wait_bits(2);
        chk("t1_idle_still_low", int'(bus.rx_idle), 0);
        wait_bits(3);
        chk("t1_idle_back", int'(bus.rx_idle), 1);
        chk("t1_strobes", n_strobe - s0, 1);
        check_bytes("t1");

        // Back-to-back frames
        send_good(8'h50);
        chk("t2_idle0", int'(bus.rx_idle), 0);
        send_good(8'h04);
        chk("t2_idle1", int'(bus.rx_idle), 0);
        send_good(8'hFF);
        chk("t2_idle2", int'(bus.rx_idle), 0);
        send_good(8'h00);
        chk("t2_idle3", int'(bus.rx_idle), 0);
        wait_bits(1);
        check_bytes("t2");

        // Short glitch
        wait_idle("t3_pre_idle");
        s0 = n_strobe;
        f0 = n_ferr;
        @(negedge FIFO_clk);
        bus.rx_pin = 1'b0;
        repeat (5) @(negedge FIFO_clk);
        bus.rx_pin = 1'b1;
        wait_bits(3);
        chk("t3_no_strobe", n_strobe - s0, 0);
        chk("t3_no_ferr", n_ferr - f0, 0);
        wait_idle("t3_idle_again");

        // Framing error then recovery
        s0 = n_strobe;
        f0 = n_ferr;
        send_frame(8'h3C, 1'b0, -1);
        @(negedge FIFO_clk);
        bus.rx_pin = 1'b1;
        wait_bits(2);
        chk("t4_ferr_once", n_ferr - f0, 1);
        chk("t4_no_strobe", n_strobe - s0, 0);
        chk("t4_data_held", int'(bus.rx_data), int'(last_byte));
        send_good(8'h12);
        wait_bits(1);
        check_bytes("t4");

        // Line break
        wait_idle("t5_pre_idle");
        s0 = n_strobe;
        f0 = n_ferr;
        @(negedge FIFO_clk);
        bus.rx_pin = 1'b0;
        wait_bits(11);
        chk("t5_brk_not_yet", int'(bus.brk), 0);
        wait_bits(2);
        chk("t5_brk_set", int'(bus.brk), 1);
        wait_bits(2);
        chk("t5_brk_held", int'(bus.brk), 1);
        bus.rx_pin = 1'b1;
        repeat (4) @(negedge FIFO_clk);
        chk("t5_brk_clear", int'(bus.brk), 0);
        chk("t5_ferr_once", n_ferr - f0, 1);
        chk("t5_no_strobe", n_strobe - s0, 0);

        // Random bytes with random gaps against the sent-byte list
        wait_idle("rnd_pre_idle");
        for (int i = 0; i < 8; i++) begin
            rb = 8'($urandom);
            send_good(rb);
            wait_bits($urandom_range(0, 3));
        end
        wait_bits(1);
        check_bytes("rnd");

        // Reset mid-frame
        wait_idle("t6_pre_idle");
        s0 = n_strobe;
        f0 = n_ferr;
        send_frame(8'hC3, 1'b1, 4);
        wait_bits(1);
        chk("t6_no_strobe", n_strobe - s0, 0);
        chk("t6_no_ferr", n_ferr - f0, 0);
        chk("t6_data_cleared", int'(bus.rx_data), 0);
        rx_q.delete();
        wait_idle("t6_idle");
        send_good(8'h81);
        wait_bits(1);
        chk("t6_one_strobe", n_strobe - s0, 1);
        chk("t6_data_held", int'(bus.rx_data), 8'h81);
        check_bytes("t6");

        chk("pulse_width_one", n_wide, 0);
        chk("strobe_ferr_disjoint", n_both, 0);
        chk("strobe_idle_rise_disjoint", n_idle_coinc, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
